// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-requester data-memory arbiter.
// The state enum, the requester id type and a one-hot helper live here.
package dmem_arb_pkg;

  localparam int NREQ = 2;

  typedef logic req_id_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  function automatic logic [NREQ-1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational round-robin pick between two requesters.
// On a tie the requester that was not served last wins.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_id_t         last,
  output logic            valid,
  output req_id_t         id
);

  assign valid = |req;
  assign id    = (&req) ? ~last : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and one-access sequencer for the 8-bit data memory.
// Each grant runs IDLE -> ACCESS -> RESP, so one access every three cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [1:0]      Req,
  input  logic [1:0]      Write,
  input  logic [AW-1:0]   Addr0,
  input  logic [AW-1:0]   Addr1,
  input  logic [7:0]      WData0,
  input  logic [7:0]      WData1,
  output logic [1:0]      Ack,
  output logic [7:0]      RData,
  output logic            Busy,
  output logic [AW-1:0]   DataAddress,
  output logic            ReadMem,
  output logic            WriteMem,
  output logic [7:0]      DataIn,
  input  logic [7:0]      DataOut,
  output arb_state_t      dbg_state
);

  // Handshake: Req[i] is a valid command held stable until Ack[i]; the
  // command fields are sampled only on the IDLE edge that grants it, and a
  // Req still high in IDLE after its Ack counts as a fresh command.

  arb_state_t      state, next_state;
  logic            grant_valid;
  req_id_t         grant_id;
  req_id_t         id_q;
  req_id_t         last_q;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [7:0]      wdata_q;

  dmem_rr_pick u_pick (
    .req   (Req),
    .last  (last_q),
    .valid (grant_valid),
    .id    (grant_id)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_valid) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    Ack      = '0;
    ReadMem  = 1'b0;
    WriteMem = 1'b0;
    case (state)
      ACCESS: begin
        ReadMem  = ~write_q;
        // A reset landing in the access cycle must not commit the store.
        WriteMem = write_q & ~Reset;
      end
      RESP:    Ack = id_onehot(id_q) & {NREQ{~Reset}};
      default: ;
    endcase
  end

  assign Busy        = (state != IDLE);
  assign DataAddress = addr_q;
  assign DataIn      = wdata_q;
  assign dbg_state   = state;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      RData   <= '0;
    end else begin
      if (state == IDLE && grant_valid) begin
        id_q    <= grant_id;
        addr_q  <= grant_id ? Addr1 : Addr0;
        write_q <= Write[grant_id];
        wdata_q <= grant_id ? WData1 : WData0;
      end
      if (state == ACCESS && !write_q) RData <= DataOut;
      if (state == RESP) last_q <= id_q;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then randomized
// rounds, predicted by a transaction-level model with a reference memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          Reset;
  logic [1:0]    Req, Write;
  logic [AW-1:0] Addr0, Addr1;
  logic [7:0]    WData0, WData1;
  logic [1:0]    Ack;
  logic [7:0]    RData;
  logic          Busy;
  logic [AW-1:0] DataAddress;
  logic          ReadMem, WriteMem;
  logic [7:0]    DataIn, DataOut;
  arb_state_t    dbg_state;

  dmem_arbiter #(.AW(AW)) dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .Write(Write),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack(Ack), .RData(RData), .Busy(Busy), .DataAddress(DataAddress),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .DataIn(DataIn),
    .DataOut(DataOut), .dbg_state(dbg_state)
  );

  // Clock / environment memory
  always #5 CLK = ~CLK;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  always @(posedge CLK) if (WriteMem) mem[DataAddress] <= DataIn;
  assign DataOut = mem[DataAddress];

  // Scoreboard and model state
  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic       last_srv;
  logic [7:0] exp_rdata;
  logic       cw [2];
  logic [7:0] ca [2];
  logic [7:0] cd [2];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    cw[i] = w; ca[i] = a; cd[i] = d;
    Write[i] = w;
    if (i == 0) begin Addr0 = a; WData0 = d; end
    else        begin Addr1 = a; WData1 = d; end
  endtask

  task automatic rand_cmd(input int i);
    logic [7:0] a;
    a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
    set_cmd(i, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
  endtask

  // One granted command: access cycle, response cycle, idle cycle.
  task automatic serve(input int id, input logic hold, input logic late0);
    logic [1:0] exp_ack;
    tick;
    check("busy_access", 32'(Busy), 1);
    check("state_access", 32'(dbg_state), 32'(ACCESS));
    check("read_en", 32'(ReadMem), 32'(!cw[id]));
    check("write_en", 32'(WriteMem), 32'(cw[id]));
    check("mem_addr", 32'(DataAddress), 32'(ca[id]));
    check("mem_wdata", 32'(DataIn), 32'(cd[id]));
    check("ack_access", 32'(Ack), 0);
    if (late0) Req[0] = 1'b1;
    tick;
    if (cw[id]) ref_mem[ca[id]] = cd[id];
    else        exp_rdata = ref_mem[ca[id]];
    exp_ack = exp_q.pop_front();
    check("ack", 32'(Ack), 32'(exp_ack));
    check("rdata", 32'(RData), 32'(exp_rdata));
    check("mem_ctl_resp", 32'({ReadMem, WriteMem}), 0);
    if (cw[id]) check("mem_content", 32'(mem[ca[id]]), 32'(cd[id]));
    last_srv = 1'(id);
    if (!hold) Req[id] = 1'b0;
    tick;
    check("busy_idle", 32'(Busy), 0);
    check("ack_idle", 32'(Ack), 0);
  endtask

  // Requests raised together (or requester 0 one cycle late) and served to completion.
  task automatic run_round(input logic [1:0] mask, input logic late0);
    int first;
    if (mask == 2'b01)                first = 0;
    else if (mask == 2'b10 || late0)  first = 1;
    else                              first = int'(!last_srv);
    exp_q.push_back(first == 1 ? 2'b10 : 2'b01);
    if (mask == 2'b11) exp_q.push_back(first == 1 ? 2'b01 : 2'b10);
    Req = late0 ? 2'b10 : mask;
    serve(first, 1'b0, late0);
    if (mask == 2'b11) serve(1 - first, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] m;
    logic       l;
    logic [7:0] old_val;
    int         id;

    Reset = 1'b1; Req = '0; Write = '0;
    Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom_range(0, 255));
      ref_mem[i] = mem[i];
    end
    last_srv  = 1'b1;
    exp_rdata = 8'h00;

    // Reset state
    repeat (3) tick;
    check("rst_busy", 32'(Busy), 0);
    check("rst_ack", 32'(Ack), 0);
    check("rst_rdata", 32'(RData), 0);
    check("rst_mem_ctl", 32'({ReadMem, WriteMem}), 0);
    check("rst_addr", 32'(DataAddress), 0);
    check("rst_din", 32'(DataIn), 0);
    Reset = 1'b0;
    tick;
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Store from requester 0, then load it back through requester 1
    set_cmd(0, 1'b1, 8'h10, 8'hA5);
    run_round(2'b01, 1'b0);
    set_cmd(1, 1'b0, 8'h10, 8'h00);
    run_round(2'b10, 1'b0);
    check("load_a5", 32'(RData), 32'h0A5);

    // Reset asserted during a store's access cycle
    old_val = ref_mem[8'h20];
    set_cmd(0, 1'b1, 8'h20, ~old_val);
    Req = 2'b01;
    tick;
    check("pre_rst_write_en", 32'(WriteMem), 1);
    Reset = 1'b1;
    #1;
    check("rst_gates_write", 32'(WriteMem), 0);
    check("rst_no_ack", 32'(Ack), 0);
    Req = 2'b00;
    tick;
    check("midrst_busy", 32'(Busy), 0);
    check("midrst_ack", 32'(Ack), 0);
    check("midrst_rdata", 32'(RData), 0);
    check("midrst_mem", 32'(mem[8'h20]), 32'(old_val));
    Reset = 1'b0;
    last_srv  = 1'b1;
    exp_rdata = 8'h00;
    tick;
    check("post_rst_idle", 32'(Busy), 0);

    // Both requesters held continuously: alternating grants, requester 0 first
    set_cmd(0, 1'b0, 8'h01, 8'($urandom_range(0, 255)));
    set_cmd(1, 1'b0, 8'h02, 8'($urandom_range(0, 255)));
    Req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      id = int'(!last_srv);
      exp_q.push_back(id == 1 ? 2'b10 : 2'b01);
      serve(id, 1'b1, 1'b0);
    end
    Req = 2'b00;

    // Requester 0 rises while requester 1 is in its access cycle
    rand_cmd(0);
    rand_cmd(1);
    run_round(2'b11, 1'b1);

    // Load from the top address
    set_cmd(0, 1'b0, 8'hFF, 8'h3C);
    run_round(2'b01, 1'b0);
    check("top_addr_data", 32'(RData), 32'(ref_mem[8'hFF]));

    // Randomized rounds
    repeat (40) begin
      m = 2'($urandom_range(1, 3));
      l = (m == 2'b11) ? 1'($urandom_range(0, 1)) : 1'b0;
      rand_cmd(0);
      rand_cmd(1);
      run_round(m, l);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
